// File: rtl/hi_sniff_conditioner.sv
// rtl/hi_sniff_conditioner.sv - ADC window reducer and hysteresis modulation detector for the HF sniff path
// Optional DC-blocking baseline on the mean output: HI_SNIFF_COND_DCBLOCK_EN
module hi_sniff_conditioner #(
   parameter int WIN_LOG2 = 3,
   parameter int HYST     = 8
) (
   input  logic       ck_1356meg,
   input  logic       reset,
   input  logic [7:0] adc_d,
   input  logic [1:0] mode,
   input  logic [7:0] thresh,
   input  logic       enable,
   output logic [7:0] sample_out,
   output logic       sample_stb,
   output logic       mod_detect,
   output logic       overrun
);

   localparam int SW = 8 + WIN_LOG2;

   logic [7:0]          adc_q;
   logic                adc_vld;
   logic [WIN_LOG2-1:0] count;
   logic [SW-1:0]       sum;
   logic [7:0]          min_v;
   logic [7:0]          max_v;
   logic [1:0]          mode_q;

   logic                act;
   logic                last;
   logic [SW-1:0]       sum_n;
   logic [7:0]          min_n;
   logic [7:0]          max_n;
   logic [7:0]          mean;
   logic [7:0]          mean_out;
   logic [7:0]          result;
   logic [8:0]          hi_sum;
   logic [7:0]          set_lvl;
   logic [7:0]          clr_lvl;

   // adc_vld keeps the reset value of adc_q out of the first window
   assign act  = enable & adc_vld;
   assign last = act & (&count);

   always_comb begin
      sum_n  = sum + {{WIN_LOG2{1'b0}}, adc_q};
      min_n  = (adc_q < min_v) ? adc_q : min_v;
      max_n  = (adc_q > max_v) ? adc_q : max_v;
      mean   = sum_n[SW-1:WIN_LOG2];
      result = mean_out;
      case (mode_q)
         2'd0: result = mean_out;
         2'd1: result = max_n - min_n;
         2'd2: result = max_n;
         2'd3: result = {max_n[7:4], min_n[7:4]};
         default: result = mean_out;
      endcase
   end

   always_comb begin
      hi_sum  = {1'b0, thresh} + 9'(HYST);
      set_lvl = hi_sum[8] ? 8'hFF : hi_sum[7:0];
      clr_lvl = ({1'b0, thresh} < 9'(HYST)) ? 8'h00 : 8'(thresh - 8'(HYST));
   end

`ifdef HI_SNIFF_COND_DCBLOCK_EN
   logic [15:0]        baseline;
   logic signed [16:0] bl_err;
   logic [15:0]        bl_next;
   logic signed [9:0]  dc_diff;

   always_comb begin
      bl_err  = $signed({1'b0, mean, 8'h00}) - $signed({1'b0, baseline});
      bl_next = baseline + 16'(bl_err >>> 4);
      dc_diff = $signed({2'b00, mean}) - $signed({2'b00, baseline[15:8]}) + 10'sd128;
      if (dc_diff < 10'sd0)
         mean_out = 8'h00;
      else if (dc_diff > 10'sd255)
         mean_out = 8'hFF;
      else
         mean_out = dc_diff[7:0];
   end

   always_ff @(posedge ck_1356meg or posedge reset) begin
      if (reset)
         baseline <= 16'h8000;
      else if (last)
         baseline <= bl_next;
   end
`else
   assign mean_out = mean;
`endif

   always_ff @(posedge ck_1356meg or posedge reset) begin
      if (reset) begin
         adc_q      <= 8'h00;
         adc_vld    <= 1'b0;
         count      <= '0;
         sum        <= '0;
         min_v      <= 8'hFF;
         max_v      <= 8'h00;
         mode_q     <= 2'd0;
         sample_out <= 8'h00;
         sample_stb <= 1'b0;
         mod_detect <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         adc_q      <= adc_d;
         adc_vld    <= 1'b1;
         sample_stb <= last;
         if (adc_q > set_lvl)
            mod_detect <= 1'b1;
         else if (adc_q < clr_lvl)
            mod_detect <= 1'b0;
         // Mode is latched on the first sample of a window; any later change is an overrun
         if ((count != '0) && (mode != mode_q))
            overrun <= 1'b1;
         if (act) begin
            if (count == '0)
               mode_q <= mode;
            count <= count + 1'b1;
            if (last) begin
               sample_out <= result;
               sum        <= '0;
               min_v      <= 8'hFF;
               max_v      <= 8'h00;
            end else begin
               sum   <= sum_n;
               min_v <= min_n;
               max_v <= max_n;
            end
         end
      end
   end

endmodule

// File: tb/tb_hi_sniff_conditioner.sv
// tb/tb_hi_sniff_conditioner.sv - bench for hi_sniff_conditioner against a queue-based window model
module tb_hi_sniff_conditioner;

   localparam int WL   = 3;
   localparam int N    = 1 << WL;
   localparam int HYST = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] adc_d = 8'h00;
   logic [1:0] mode = 2'd0;
   logic [7:0] thresh = 8'h80;
   logic       enable = 1'b0;
   logic [7:0] sample_out;
   logic       sample_stb;
   logic       mod_detect;
   logic       overrun;

   int vectors = 0;
   int errors  = 0;

   int m_prev_adc;
   bit m_prev_vld;
   int m_win[$];
   int m_mode;
   int m_out;
   bit m_stb;
   bit m_mod;
   bit m_ovr;

   hi_sniff_conditioner #(.WIN_LOG2(WL), .HYST(HYST)) dut (
      .ck_1356meg(clk),
      .reset(reset),
      .adc_d(adc_d),
      .mode(mode),
      .thresh(thresh),
      .enable(enable),
      .sample_out(sample_out),
      .sample_stb(sample_stb),
      .mod_detect(mod_detect),
      .overrun(overrun)
   );

   always #37 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int reduce_win(input int md);
      int s;
      int mn;
      int mx;
      s  = 0;
      mn = 255;
      mx = 0;
      foreach (m_win[i]) begin
         s += m_win[i];
         if (m_win[i] < mn) mn = m_win[i];
         if (m_win[i] > mx) mx = m_win[i];
      end
      case (md)
         0:       return s / N;
         1:       return mx - mn;
         2:       return mx;
         default: return (mx / 16) * 16 + mn / 16;
      endcase
   endfunction

   task automatic model_reset();
      m_prev_adc = 0;
      m_prev_vld = 0;
      m_win.delete();
      m_mode = 0;
      m_out  = 0;
      m_stb  = 0;
      m_mod  = 0;
      m_ovr  = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_out", sample_out, 8'h00);
      chk("rst_stb", {7'd0, sample_stb}, 8'h00);
      chk("rst_mod", {7'd0, mod_detect}, 8'h00);
      chk("rst_ovr", {7'd0, overrun}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step(input int a, input bit en, input int md, input int th);
      int hi;
      int lo;
      adc_d  = 8'(a);
      enable = en;
      mode   = 2'(md);
      thresh = 8'(th);
      @(posedge clk);
      hi = (th + HYST > 255) ? 255 : th + HYST;
      lo = (th - HYST < 0) ? 0 : th - HYST;
      if (m_prev_adc > hi)
         m_mod = 1;
      else if (m_prev_adc < lo)
         m_mod = 0;
      if (m_win.size() != 0 && md != m_mode)
         m_ovr = 1;
      m_stb = 0;
      if (en && m_prev_vld) begin
         if (m_win.size() == 0)
            m_mode = md;
         m_win.push_back(m_prev_adc);
         if (m_win.size() == N) begin
            m_out = reduce_win(m_mode);
            m_stb = 1;
            m_win.delete();
         end
      end
      m_prev_adc = a;
      m_prev_vld = 1;
      #1;
      chk("stb", {7'd0, sample_stb}, {7'd0, m_stb});
      chk("out", sample_out, 8'(m_out));
      chk("mod", {7'd0, mod_detect}, {7'd0, m_mod});
      chk("ovr", {7'd0, overrun}, {7'd0, m_ovr});
      @(negedge clk);
   endtask

   initial begin
      int first;
      int gap;
      bit seen;
      logic [7:0] mods [7];
      int seq [5] = '{8'h85, 8'h89, 8'h85, 8'h77, 8'h79};
      int md;
      int th;

      // constant input, mean mode, first strobe latency
      do_reset();
      first = 0;
      for (int i = 1; i <= 25; i++) begin
         step(8'h40, 1, 0, 8'h80);
         if (sample_stb && first == 0) first = i;
      end
      chk("first_stb_cycle", 8'(first), 8'd9);
      chk("const_mean", sample_out, 8'h40);

      // ramp window in modes 1..3
      for (int m = 1; m <= 3; m++) begin
         do_reset();
         for (int i = 0; i < 8; i++) step(8'h10 * (i + 1), 1, m, 8'h80);
         step(8'h00, 1, m, 8'h80);
         if (m == 1) chk("ramp_p2p", sample_out, 8'h70);
         if (m == 2) chk("ramp_max", sample_out, 8'h80);
         if (m == 3) chk("ramp_pack", sample_out, 8'h81);
      end

      // hysteresis sequence around 0x80
      do_reset();
      step(8'h70, 1, 0, 8'h80);
      step(8'h70, 1, 0, 8'h80);
      for (int i = 0; i < 7; i++) begin
         step((i < 5) ? seq[i] : 8'h79, 1, 0, 8'h80);
         mods[i] = {7'd0, mod_detect};
      end
      chk("hyst0", mods[0], 8'd0);
      chk("hyst1", mods[1], 8'd0);
      chk("hyst2_set", mods[2], 8'd1);
      chk("hyst3_hold", mods[3], 8'd1);
      chk("hyst4_clr", mods[4], 8'd0);
      chk("hyst6", mods[6], 8'd0);

      // saturated set level never trips
      for (int i = 0; i < 6; i++) step(8'hFF, 1, 0, 250);
      chk("sat_no_set", {7'd0, mod_detect}, 8'd0);

      // enable drop delays the next strobe by exactly its length
      do_reset();
      for (int i = 0; i < 9; i++) step(8'h5A, 1, 0, 8'h80);
      gap = 0;
      for (int i = 0; i < 3; i++) begin step(8'h5A, 1, 0, 8'h80); gap++; end
      for (int i = 0; i < 5; i++) begin step(8'h5A, 0, 0, 8'h80); gap++; end
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(8'h5A, 1, 0, 8'h80);
         gap++;
         seen = sample_stb;
      end
      chk("en_gap", 8'(gap), 8'd13);
      chk("en_mean", sample_out, 8'h5A);

      // mode change mid-window: old mode for this window, sticky overrun
      do_reset();
      for (int i = 0; i < 4; i++) step(8'h30, 1, 0, 8'h80);
      for (int i = 0; i < 5; i++) step(8'h30, 1, 1, 8'h80);
      chk("ovr_set", {7'd0, overrun}, 8'd1);
      chk("ovr_old_mode", sample_out, 8'h30);
      for (int i = 0; i < 10; i++) step(8'h30, 1, 1, 8'h80);
      chk("ovr_sticky", {7'd0, overrun}, 8'd1);
      for (int i = 0; i < 3; i++) step(8'h90, 1, 1, 8'h80);
      do_reset();

      // randomized traffic
      md = 0;
      th = 8'h80;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         if ($urandom_range(0, 63) == 0) md = $urandom_range(0, 3);
         if ($urandom_range(0, 31) == 0) th = $urandom_range(0, 255);
         step($urandom_range(0, 255), $urandom_range(0, 9) != 0, md, th);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
